// File: rtl/videomem_vga_out.sv
// videomem_vga_out
//   Video memory plus VGA scan-out for the 6-bit image/font placer.
//   Holds an H_ACTIVE x V_ACTIVE array of 6-bit pixels {R[1:0],G[1:0],B[1:0]},
//   accepts the placer's write stream, zeroes the whole memory after reset and
//   scans it out as VGA with syncs, blanking and 8-bit colour channels.
//
// Ports
//   clk          system clock (50 MHz); the pixel rate is clk/2
//   rst_n        synchronous reset, active-low
//   waddr        write address, linear y*H_ACTIVE+x
//   wdata        pixel {R[1:0],G[1:0],B[1:0]}
//   we           write enable, one pixel per clk, never stalled
//   clr_busy     high while the post-reset clear is running
//   frame_tick   one-clk pulse at the start of vertical blanking
//   VGA_CLK      pixel clock, registered copy of the pixel toggle
//   VGA_HS/VS    syncs, active-low
//   VGA_BLANK_N  high during active video
//   VGA_SYNC_N   tied low
//   VGA_R/G/B    8-bit colour, zero outside active video
module videomem_vga_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [18:0] waddr,
  input  logic [5:0]  wdata,
  input  logic        we,
  output logic        clr_busy,
  output logic        frame_tick,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DEPTH   = H_ACTIVE * V_ACTIVE;
  localparam int AW      = $clog2(DEPTH);

  localparam logic [9:0]  H_ACT_C    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT_C    = 10'(V_ACTIVE);
  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  HS_BEG     = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEG     = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [18:0] MEM_SIZE   = 19'(DEPTH);
  localparam logic [18:0] MEM_LAST   = 19'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} clrState_e;

  clrState_e   state_q, state_d;
  logic [18:0] clrAddr_q, clrAddr_d;
  logic [9:0]  hCnt_q, hCnt_d;
  logic [9:0]  vCnt_q, vCnt_d;
  logic [18:0] rdAddr_q, rdAddr_d;
  logic        pixTgl_q, vgaClk_q;
  logic        actS1_q, hsS1_q, vsS1_q;
  logic        hs_q, vs_q, blank_q, frameTick_q;
  logic [7:0]  red_q, grn_q, blu_q;
  logic [5:0]  rdData_q;
  logic [5:0]  mem [DEPTH];

  logic        pixEn, activeNow, hsZone, vsZone;
  logic        memWe;
  logic [18:0] memWAddr;
  logic [5:0]  memWData;

  // Timing decodes of the current counter state.
  always_comb begin
    pixEn     = pixTgl_q;
    activeNow = (hCnt_q < H_ACT_C) && (vCnt_q < V_ACT_C);
    hsZone    = (hCnt_q >= HS_BEG) && (hCnt_q < HS_END);
    vsZone    = (vCnt_q >= VS_BEG) && (vCnt_q < VS_END);
  end

  // Clear sequencer: walk every address once writing black, then hand the
  // write port to the placer for good.
  always_comb begin
    state_d   = state_q;
    clrAddr_d = clrAddr_q;
    case (state_q)
      CLEAR: begin
        if (clrAddr_q == MEM_LAST) begin
          state_d = RUN;
        end else begin
          clrAddr_d = clrAddr_q + 19'd1;
        end
      end
      default: ;
    endcase
  end

  // Write port mux. Out-of-range addresses are dropped instead of wrapping,
  // and nothing is written on a reset clock.
  always_comb begin
    memWe    = 1'b0;
    memWAddr = waddr;
    memWData = wdata;
    if (rst_n) begin
      if (state_q == CLEAR) begin
        memWe    = 1'b1;
        memWAddr = clrAddr_q;
        memWData = 6'd0;
      end else begin
        memWe = we && (waddr < MEM_SIZE);
      end
    end
  end

  // Scan counters. The read address follows the active pixels incrementally,
  // which replaces a y*width multiply; it only rewinds at the end of a frame.
  always_comb begin
    hCnt_d   = hCnt_q;
    vCnt_d   = vCnt_q;
    rdAddr_d = rdAddr_q;
    if (pixEn) begin
      if (hCnt_q == H_LAST) begin
        hCnt_d = '0;
        vCnt_d = (vCnt_q == V_LAST) ? 10'd0 : vCnt_q + 10'd1;
      end else begin
        hCnt_d = hCnt_q + 10'd1;
      end
      if ((hCnt_q == H_LAST) && (vCnt_q == V_LAST)) begin
        rdAddr_d = '0;
      end else if (activeNow) begin
        rdAddr_d = rdAddr_q + 19'd1;
      end
    end
  end

  // Memory write side. No reset so it maps onto block RAM; writes land with
  // non-blocking semantics, so a same-clock read sees the old pixel.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memWAddr[AW-1:0]] <= memWData;
    end
  end

  // All control, pipeline and output registers. Sync and blanking pass
  // through one stage (S1) while the memory read is in flight, so colour and
  // timing leave on the same pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      clrAddr_q   <= '0;
      hCnt_q      <= '0;
      vCnt_q      <= '0;
      rdAddr_q    <= '0;
      pixTgl_q    <= 1'b0;
      vgaClk_q    <= 1'b0;
      actS1_q     <= 1'b0;
      hsS1_q      <= 1'b1;
      vsS1_q      <= 1'b1;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_q     <= 1'b0;
      red_q       <= '0;
      grn_q       <= '0;
      blu_q       <= '0;
      rdData_q    <= '0;
      frameTick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clrAddr_q   <= clrAddr_d;
      hCnt_q      <= hCnt_d;
      vCnt_q      <= vCnt_d;
      rdAddr_q    <= rdAddr_d;
      pixTgl_q    <= ~pixTgl_q;
      vgaClk_q    <= pixTgl_q;
      frameTick_q <= pixEn && (hCnt_q == H_LAST) && (vCnt_q == V_ACT_LAST);
      if (pixEn) begin
        rdData_q <= mem[rdAddr_q[AW-1:0]];
        actS1_q  <= activeNow;
        hsS1_q   <= ~hsZone;
        vsS1_q   <= ~vsZone;
        hs_q     <= hsS1_q;
        vs_q     <= vsS1_q;
        blank_q  <= actS1_q;
        red_q    <= actS1_q ? {4{rdData_q[5:4]}} : 8'd0;
        grn_q    <= actS1_q ? {4{rdData_q[3:2]}} : 8'd0;
        blu_q    <= actS1_q ? {4{rdData_q[1:0]}} : 8'd0;
      end
    end
  end

  assign clr_busy    = (state_q == CLEAR);
  assign frame_tick  = frameTick_q;
  assign VGA_CLK     = vgaClk_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = red_q;
  assign VGA_G       = grn_q;
  assign VGA_B       = blu_q;

endmodule

// File: tb/tb_videomem_vga_out.sv
// tb_videomem_vga_out
//   Bench for videomem_vga_out on a shrunken 16x8 raster so whole frames and
//   the full clear fit in a short run. The reference model derives the pixel
//   position from the number of clocks since reset and keeps its own copy of
//   the video memory.
module tb_videomem_vga_out;

  localparam int HA = 16, HF = 2, HSW = 4, HB = 2;
  localparam int VA = 8,  VF = 2, VSW = 1, VB = 2;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;
  localparam int DEPTH = HA * VA;
  localparam int AW = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [18:0] waddr = '0;
  logic [5:0]  wdata = '0;
  logic        we = 1'b0;
  logic        clr_busy, frame_tick, VGA_CLK, VGA_HS, VGA_VS;
  logic        VGA_BLANK_N, VGA_SYNC_N;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  videomem_vga_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .waddr(waddr), .wdata(wdata), .we(we),
    .clr_busy(clr_busy), .frame_tick(frame_tick), .VGA_CLK(VGA_CLK),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #10 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Drive one clock worth of write-port inputs.
  task automatic applyStimulus(input logic w, input logic [18:0] a, input logic [5:0] d);
    we    = w;
    waddr = a;
    wdata = d;
    @(posedge clk);
    #1;
  endtask

  // Pixel index q counts pixel periods since reset; position follows from it.
  function automatic int pixH(input int q);
    return (q % FRAME) % HT;
  endfunction

  function automatic int pixV(input int q);
    return (q % FRAME) / HT;
  endfunction

  function automatic bit isActive(input int q);
    return (pixH(q) < HA) && (pixV(q) < VA);
  endfunction

  function automatic logic [7:0] expand(input logic [1:0] x);
    return 8'(x * 85);
  endfunction

  // Reference memory, plus the pixel value captured at each read time.
  logic [5:0] mdl [DEPTH];
  logic [5:0] snap [4];
  int         edgeCnt = 0;
  bit         started = 1'b0;

  // Model update on each clock: the first DEPTH clocks after reset are the
  // clear, afterwards in-range writes land. A read of pixel q happens on clock
  // 2q+2 and sees memory as it stood before that clock's write.
  always @(posedge clk) begin
    if (!rst_n) begin
      edgeCnt <= 0;
      started <= 1'b1;
    end else if (started) begin
      edgeCnt <= edgeCnt + 1;
      if (edgeCnt + 1 <= DEPTH) begin
        mdl[AW'(edgeCnt)] <= 6'd0;
      end else if (we && (waddr < 19'(DEPTH))) begin
        mdl[waddr[AW-1:0]] <= wdata;
      end
      if (((edgeCnt + 1) % 2 == 0) && isActive((edgeCnt + 1) / 2 - 1)) begin
        snap[2'((edgeCnt + 1) / 2 - 1)] <=
          mdl[AW'(pixV((edgeCnt + 1) / 2 - 1) * HA + pixH((edgeCnt + 1) / 2 - 1))];
      end
    end
  end

  function automatic bit expTick(input int k);
    return (k >= 2) && (k % 2 == 0) && ((k / 2) % FRAME == VA * HT);
  endfunction

  function automatic bit expHs(input int k);
    if (k < 4) return 1'b1;
    return !((pixH(k / 2 - 2) >= HA + HF) && (pixH(k / 2 - 2) < HA + HF + HSW));
  endfunction

  function automatic bit expVs(input int k);
    if (k < 4) return 1'b1;
    return !((pixV(k / 2 - 2) >= VA + VF) && (pixV(k / 2 - 2) < VA + VF + VSW));
  endfunction

  function automatic bit expBlankN(input int k);
    if (k < 4) return 1'b0;
    return isActive(k / 2 - 2);
  endfunction

  function automatic logic [23:0] expRgb(input int k);
    logic [5:0] p;
    if (k < 4) return 24'd0;
    if (!isActive(k / 2 - 2)) return 24'd0;
    p = snap[2'(k / 2 - 2)];
    return {expand(p[5:4]), expand(p[3:2]), expand(p[1:0])};
  endfunction

  // Compare every output against the model once per clock, away from the edge.
  always @(negedge clk) begin
    if (started) begin
      checkOutput("clr_busy", 32'(clr_busy), 32'(edgeCnt < DEPTH));
      checkOutput("VGA_CLK", 32'(VGA_CLK), (edgeCnt >= 1) ? 32'((edgeCnt - 1) % 2) : 32'd0);
      checkOutput("frame_tick", 32'(frame_tick), 32'(expTick(edgeCnt)));
      checkOutput("VGA_SYNC_N", 32'(VGA_SYNC_N), 32'd0);
      checkOutput("VGA_HS", 32'(VGA_HS), 32'(expHs(edgeCnt)));
      checkOutput("VGA_VS", 32'(VGA_VS), 32'(expVs(edgeCnt)));
      checkOutput("VGA_BLANK_N", 32'(VGA_BLANK_N), 32'(expBlankN(edgeCnt)));
      checkOutput("RGB", 32'({VGA_R, VGA_G, VGA_B}), 32'(expRgb(edgeCnt)));
    end
  end

  // Random write with a bias towards in-range addresses and a few just past the end.
  task automatic randomWrites(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'($urandom_range(0, 2) != 0), 19'($urandom_range(0, DEPTH + 3)),
                    6'($urandom));
    end
  endtask

  // Main sequence: clear with ignored writes, directed corner writes, a write
  // colliding with the last pixel's read, random traffic, a mid-line reset.
  initial begin
    bit hit;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    applyStimulus(1'b1, 19'd5, 6'h3F);
    randomWrites(DEPTH + 4);

    applyStimulus(1'b1, 19'd0, 6'h3F);
    applyStimulus(1'b1, 19'(HA - 1), 6'h30);
    applyStimulus(1'b1, 19'(DEPTH), 6'h3F);
    applyStimulus(1'b0, 19'd0, 6'h00);

    hit = 1'b0;
    for (int i = 0; i < 4 * FRAME + 8 && !hit; i++) begin
      if ((edgeCnt % 2 == 1) && (((edgeCnt - 1) / 2) % FRAME == (VA - 1) * HT + HA - 1)) begin
        hit = 1'b1;
        applyStimulus(1'b1, 19'(DEPTH - 1), 6'h0C);
      end else begin
        applyStimulus(1'b0, 19'd0, 6'h00);
      end
    end
    checkOutput("collisionAlign", 32'(hit), 32'd1);
    repeat (2 * FRAME) applyStimulus(1'b0, 19'd0, 6'h00);

    randomWrites(6 * FRAME);

    hit = 1'b0;
    for (int i = 0; i < 4 * FRAME + 8 && !hit; i++) begin
      if ((edgeCnt % 2 == 0) && ((edgeCnt / 2) % FRAME == 3 * HT + 5)) begin
        hit = 1'b1;
        rst_n = 1'b0;
        applyStimulus(1'b1, 19'd7, 6'h15);
        rst_n = 1'b1;
      end else begin
        applyStimulus(1'b0, 19'd0, 6'h00);
      end
    end
    checkOutput("resetAlign", 32'(hit), 32'd1);

    randomWrites(DEPTH + 4 * FRAME);
    repeat (4) applyStimulus(1'b0, 19'd0, 6'h00);

    $display("%0d/%0d checks passed", nChecks - nFails, nChecks);
    $finish;
  end

endmodule

// File: doc/videomem_vga_out.md
Name: videomem_vga_out

Overview:
Downstream consumer of the 6-bit image/font placer. Holds the 640x480 6-bit video memory and accepts the placer's waddr/wdata/we write stream. Scans the memory out as 640x480@60 VGA with syncs and expanded 8-bit RGB. Clears memory to black after reset and issues a once-per-frame tick for game logic.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, HS pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, VS pulse width (lines)
V_BP, 33, vertical back porch (lines)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  reset, active-low
waddr  in  19  write address, linear y*640+x
wdata  in  6  pixel {R[1:0],G[1:0],B[1:0]}
we  in  1  write enable, one pixel per clk
clr_busy  out  1  high while post-reset clear runs
frame_tick  out  1  one-clk pulse at start of vertical blanking
VGA_CLK  out  1  pixel clock, clk/2
VGA_HS  out  1  horizontal sync, active-low
VGA_VS  out  1  vertical sync, active-low
VGA_BLANK_N  out  1  high during active video
VGA_SYNC_N  out  1  tied 0
VGA_R  out  8  red
VGA_G  out  8  green
VGA_B  out  8  blue

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst_n). Every register resets on the first posedge with rst_n=0.
- Reset values: VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB=0, VGA_CLK=0, frame_tick=0, clr_busy=1.
- Counters reset to 0: h_cnt, v_cnt, raddr, clr_addr, pixel toggle.
- Pixel strobe: pix_en toggles every clk, starting at 0 after reset.
- VGA_CLK is a registered copy of the toggle, so it rises on the clk after pix_en.
- h_cnt counts 0..799 and advances on pix_en. On wrap to 0, v_cnt advances through 0..524 and wraps to 0.
- Active region: h_cnt<640 and v_cnt<480.
- HS low for h_cnt 656..751. VS low for v_cnt 490..491.
- raddr is maintained incrementally, with no multiplier:
  - +1 on pix_en while active.
  - Reset to 0 on pix_en when h_cnt=799 and v_cnt=524.
- Memory: 307200 x 6, simple dual port, 1-clk registered read.
  - Read issued on the pix_en cycle.
  - Data is consumed on the next pix_en.
  - Read-during-write to the same address returns old data.
- Outputs are registered on pix_en with exactly one pixel of latency. HS, VS, BLANK_N and RGB all reflect the counter state of the previous pix_en, so they stay aligned.
- Colour expansion: each 2-bit field is replicated 4 times to 8 bits. Example: 2'b10 -> 8'hAA.
- RGB is forced to 0 when not active.
- Write port:
  - Memory is written at waddr with wdata when we=1, waddr<307200 and clr_busy=0.
  - Writes with waddr>=307200 are dropped; there is no wrap or aliasing.
  - The write port never stalls, and the upstream placer has no backpressure.
- Clear sequencer (states CLEAR, RUN):
  - After reset the block is in CLEAR. It writes 0 at clr_addr, incrementing once per clk from 0 to 307199. External we is ignored.
  - After writing address 307199 it moves to RUN on the next clk, and clr_busy falls with that transition.
  - Scan-out runs normally during CLEAR.
  - Reset mid-clear restarts the clear at 0.
- frame_tick: one-clk pulse on the clk after the pix_en where v_cnt becomes 480 with h_cnt=0. Exactly one pulse per frame.
- Reset mid-frame: on the next clk all outputs return to reset values; scan restarts at h=0, v=0 and the clear restarts.

Test Plan:
1. Release reset and count clks -> clr_busy=1 for exactly 307200 clks, then 0. A we=1 write to waddr=5 during the clear is ignored (pixel 5 reads as 0 in the first RUN frame).
2. After clear, write waddr=0 data 6'h3F and waddr=639 data 6'h30 -> in the next frame, line 0 pixel 0 is RGB FF/FF/FF and pixel 639 is R=FF G=00 B=00. All other line-0 pixels are 00/00/00, and BLANK_N is high for exactly 640 pixels.
3. Free-run timing:
   - HS low for 192 clks, period 1600 clks.
   - VS low for 3200 clks, frame period 840000 clks.
   - frame_tick spacing 840000 clks.
   - RGB=0 whenever BLANK_N=0.
4. Write waddr=307200 data 6'h3F, then read frame -> no pixel changes; address 0 is unchanged.
5. Write waddr=640*479+639 data 6'h0C -> last visible pixel is G=FF, R=B=00. The write collides with that pixel's read on the same clk, so the displayed value changes one frame later.
6. Assert rst_n=0 for 1 clk mid-line (v=100, h=300) -> next clk: HS=VS=1, BLANK_N=0, RGB=0, clr_busy=1. The full clear runs again and the timing restarts at h=0, v=0.
